fifo_shift_ctrl: RTL and testbench

Single-clock shift-register FIFO with occupancy tracking, an oldest-entry pop port and an indexed random-read port. Successor to the plain shift-register buffer: adds push/pop flow control, full/empty/count status, sticky error flags and validity-qualified indexed reads. It sits in the datapath as the sample-history buffer. Producers push new words, consumers drain the oldest, and tap logic reads any stored word by age.

---
 rtl/fifo_shift_ctrl.sv | 97 +++++++++
 tb/tb_fifo_shift_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_shift_ctrl: shift-register FIFO with occupancy, oldest-entry pop and   |
// | age-indexed random read.  Rev 1.0                                          |
// +----------------------------------------------------------------------------+
module fifo_shift_ctrl #(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_WORDS  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  fifo_reset_n,
  input  logic [BIT_WIDTH-1:0]  write_data,
  input  logic                  write_en,
  input  logic                  pop_en,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic                  read_en,
  output logic [BIT_WIDTH-1:0]  read_data,
  output logic                  read_valid,
  output logic [BIT_WIDTH-1:0]  pop_data,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH:0] ONE_COUNT  = (ADDR_WIDTH+1)'(1);

  logic [BIT_WIDTH-1:0]  reg_file [0:NUM_WORDS-1];
  logic [ADDR_WIDTH:0]   count_q;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  read_hit;
  logic [ADDR_WIDTH-1:0] oldest_idx;

  // Status is decoded from the count register only.
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign pop_ok     = pop_en && !empty;
  assign push_ok    = write_en && (!full || pop_ok);
  assign read_hit   = ({1'b0, index} < count_q) && ({1'b0, index} < FULL_COUNT);
  assign oldest_idx = ADDR_WIDTH'(count_q - ONE_COUNT);

  // Storage carries no reset; stale words are hidden by the count.
  always_ff @(posedge clk) begin
    if (fifo_reset_n && push_ok) begin
      for (int k = NUM_WORDS - 1; k > 0; k--) begin
        reg_file[k] <= reg_file[k-1];
      end
      reg_file[0] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!fifo_reset_n) begin
      count_q    <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      pop_data   <= '0;
      pop_valid  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok && !pop_ok) begin
        count_q <= count_q + ONE_COUNT;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - ONE_COUNT;
      end

      pop_valid <= pop_ok;
      if (pop_ok) begin
        pop_data <= reg_file[oldest_idx];
      end

      if (write_en && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop_en && !pop_ok) begin
        underflow <= 1'b1;
      end

      // read_data holds its value when no read is requested.
      read_valid <= read_en && read_hit;
      if (read_en) begin
        read_data <= read_hit ? reg_file[index] : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_shift_ctrl: directed self-checking bench for fifo_shift_ctrl.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fifo_shift_ctrl;

  logic        clk;
  logic        fifo_reset_n;
  logic [15:0] write_data;
  logic        write_en;
  logic        pop_en;
  logic [5:0]  index;
  logic        read_en;
  logic [15:0] read_data;
  logic        read_valid;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [6:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;

  fifo_shift_ctrl #(
    .BIT_WIDTH (16),
    .NUM_WORDS (64),
    .ADDR_WIDTH(6)
  ) dut (
    .clk         (clk),
    .fifo_reset_n(fifo_reset_n),
    .write_data  (write_data),
    .write_en    (write_en),
    .pop_en      (pop_en),
    .index       (index),
    .read_en     (read_en),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en   = 1'b0;
    pop_en     = 1'b0;
    read_en    = 1'b0;
    write_data = '0;
    index      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    fifo_reset_n = 1'b0;
    tick();
    fifo_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b, required 0/1/0", count, empty, full);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || pop_valid !== 1'b0 || read_valid !== 1'b0 ||
        pop_data !== 16'h0 || read_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: ovf=%b unf=%b pv=%b rv=%b pd=%h rd=%h, required all 0",
               overflow, underflow, pop_valid, read_valid, pop_data, read_data);
    end
    read_en = 1'b1;
    index   = 6'd0;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b0 || read_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_read0: rv=%b rd=%h, required 0/0000", read_valid, read_data);
    end
  endtask

  task automatic test_push_read();
    for (int i = 1; i <= 4; i++) begin
      write_en   = 1'b1;
      write_data = 16'(i);
      tick();
    end
    idle_inputs();
    checks++;
    if (count !== 7'd4 || empty !== 1'b0) begin
      errors++;
      $display("FAIL push4_count: count=%0d empty=%b, required 4/0", count, empty);
    end
    for (int i = 0; i < 4; i++) begin
      read_en = 1'b1;
      index   = 6'(i);
      tick();
      checks++;
      if (read_valid !== 1'b1 || read_data !== 16'(4 - i)) begin
        errors++;
        $display("FAIL read_idx%0d: rv=%b rd=%h, required 1/%h", i, read_valid, read_data, 16'(4 - i));
      end
    end
    index = 6'd4;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b0 || read_data !== 16'h0) begin
      errors++;
      $display("FAIL read_idx4: rv=%b rd=%h, required 0/0000", read_valid, read_data);
    end
  endtask

  task automatic test_back_to_back_pop();
    pop_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== 16'(i)) begin
        errors++;
        $display("FAIL pop%0d: pv=%b pd=%h, required 1/%h", i, pop_valid, pop_data, 16'(i));
      end
    end
    pop_en = 1'b0;
    tick();
    checks++;
    if (pop_valid !== 1'b0 || empty !== 1'b1 || count !== 7'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL pop_drained: pv=%b empty=%b count=%0d unf=%b, required 0/1/0/0",
               pop_valid, empty, count, underflow);
    end
    pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
    checks++;
    if (underflow !== 1'b1 || pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_underflow: unf=%b pv=%b, required 1/0", underflow, pop_valid);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      write_en   = 1'b1;
      write_data = 16'h0100 + 16'(i);
      tick();
    end
    idle_inputs();
    checks++;
    if (full !== 1'b1 || count !== 7'd64 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill64: full=%b count=%0d ovf=%b, required 1/64/0", full, count, overflow);
    end
    write_en   = 1'b1;
    write_data = 16'hDEAD;
    tick();
    idle_inputs();
    checks++;
    if (overflow !== 1'b1 || count !== 7'd64) begin
      errors++;
      $display("FAIL overflow: ovf=%b count=%0d, required 1/64", overflow, count);
    end
    read_en = 1'b1;
    index   = 6'd0;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 16'h013F) begin
      errors++;
      $display("FAIL overflow_entry0: rv=%b rd=%h, required 1/013f", read_valid, read_data);
    end
    write_en   = 1'b1;
    pop_en     = 1'b1;
    write_data = 16'hBEEF;
    tick();
    idle_inputs();
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 16'h0100 || count !== 7'd64) begin
      errors++;
      $display("FAIL full_pushpop: pv=%b pd=%h count=%0d, required 1/0100/64", pop_valid, pop_data, count);
    end
    read_en = 1'b1;
    index   = 6'd0;
    tick();
    checks++;
    if (read_valid !== 1'b1 || read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL full_entry0: rv=%b rd=%h, required 1/beef", read_valid, read_data);
    end
    index = 6'd63;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 16'h0101) begin
      errors++;
      $display("FAIL full_entry63: rv=%b rd=%h, required 1/0101", read_valid, read_data);
    end
  endtask

  task automatic test_empty_pushpop();
    do_reset();
    write_en   = 1'b1;
    pop_en     = 1'b1;
    write_data = 16'h00AA;
    tick();
    idle_inputs();
    checks++;
    if (count !== 7'd1 || underflow !== 1'b1 || pop_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_pushpop: count=%0d unf=%b pv=%b ovf=%b, required 1/1/0/0",
               count, underflow, pop_valid, overflow);
    end
    read_en = 1'b1;
    index   = 6'd0;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b1 || read_data !== 16'h00AA) begin
      errors++;
      $display("FAIL empty_pushpop_read: rv=%b rd=%h, required 1/00aa", read_valid, read_data);
    end
  endtask

  task automatic test_mid_reset();
    // Build up traffic with underflow already set from the previous scenario.
    for (int i = 0; i < 5; i++) begin
      write_en   = 1'b1;
      pop_en     = (i >= 2);
      read_en    = 1'b1;
      index      = 6'(i % 2);
      write_data = 16'h0A00 + 16'(i);
      tick();
    end
    fifo_reset_n = 1'b0;
    tick();
    fifo_reset_n = 1'b1;
    idle_inputs();
    checks++;
    if (count !== 7'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
        pop_valid !== 1'b0 || read_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b ovf=%b unf=%b pv=%b rv=%b, required 0/1/0/0/0/0",
               count, empty, overflow, underflow, pop_valid, read_valid);
    end
    read_en = 1'b1;
    index   = 6'd0;
    tick();
    read_en = 1'b0;
    checks++;
    if (read_valid !== 1'b0 || read_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_read0: rv=%b rd=%h, required 0/0000", read_valid, read_data);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    fifo_reset_n = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_push_read();
    test_back_to_back_pop();
    test_full();
    test_empty_pushpop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
